// File: rtl/radarpim_reset_sequencer.sv
// Staged reset release after PLL lock: cores first, peripherals STAGE_GAP cycles later.
// Define RADARPIM_RESET_SWRST_EN to add the sw_rst_req software reset input.
module radarpim_reset_sequencer #(
  parameter int unsigned HOLD_CYCLES = 1024,
  parameter int unsigned STAGE_GAP   = 16
) (
  input  logic       clk_system,
  input  logic       rst,
  input  logic       pll_locked,
`ifdef RADARPIM_RESET_SWRST_EN
  input  logic       sw_rst_req,
`endif
  output logic       rstnn_core,
  output logic       rstnn_periph,
  output logic       sys_ready,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [1:0] {WAIT_LOCK, HOLD, REL_CORE, RUN} state_t;

  localparam logic [15:0] HOLD_LAST = 16'(HOLD_CYCLES - 1);
  localparam logic [15:0] GAP_LAST  = 16'(STAGE_GAP - 1);

  state_t      state, state_next;
  logic [15:0] cnt, cnt_next;
  logic        sync_meta, lock_sync;
  logic        lock_loss, sw_abort;

  always_ff @(posedge clk_system or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      lock_sync <= 1'b0;
    end else begin
      sync_meta <= pll_locked;
      lock_sync <= sync_meta;
    end
  end

`ifdef RADARPIM_RESET_SWRST_EN
  assign sw_abort = sw_rst_req;
`else
  assign sw_abort = 1'b0;
`endif

  // Lock loss takes priority over a simultaneous software reset so it is always counted.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    lock_loss  = 1'b0;
    if (state != WAIT_LOCK && !lock_sync) begin
      state_next = WAIT_LOCK;
      cnt_next   = 16'd0;
      lock_loss  = 1'b1;
    end else if (state != WAIT_LOCK && sw_abort) begin
      state_next = WAIT_LOCK;
      cnt_next   = 16'd0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          cnt_next = 16'd0;
          if (lock_sync && !sw_abort) state_next = HOLD;
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state_next = REL_CORE;
            cnt_next   = 16'd0;
          end else begin
            cnt_next = cnt + 16'd1;
          end
        end
        REL_CORE: begin
          if (cnt == GAP_LAST) begin
            state_next = RUN;
            cnt_next   = 16'd0;
          end else begin
            cnt_next = cnt + 16'd1;
          end
        end
        RUN:     cnt_next = 16'd0;
        default: begin
          state_next = WAIT_LOCK;
          cnt_next   = 16'd0;
        end
      endcase
    end
  end

  // Outputs decode next state so they switch on the same edge as the state.
  always_ff @(posedge clk_system or posedge rst) begin
    if (rst) begin
      state         <= WAIT_LOCK;
      cnt           <= 16'd0;
      rstnn_core    <= 1'b0;
      rstnn_periph  <= 1'b0;
      sys_ready     <= 1'b0;
      lock_loss_cnt <= 8'd0;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      rstnn_core   <= (state_next == REL_CORE) || (state_next == RUN);
      rstnn_periph <= (state_next == RUN);
      sys_ready    <= (state_next == RUN);
      if (lock_loss && lock_loss_cnt != 8'hFF) lock_loss_cnt <= lock_loss_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_radarpim_reset_sequencer.sv
// Directed bench for radarpim_reset_sequencer with HOLD_CYCLES=8, STAGE_GAP=4.
module tb_radarpim_reset_sequencer;

  logic       clk_system = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       sw_rst_req = 1'b0;
  logic       rstnn_core, rstnn_periph, sys_ready;
  logic [7:0] lock_loss_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       rst;
    logic       pll;
    logic       exp_core;
    logic       exp_periph;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  radarpim_reset_sequencer #(.HOLD_CYCLES(8), .STAGE_GAP(4)) dut (
    .clk_system   (clk_system),
    .rst          (rst),
    .pll_locked   (pll_locked),
`ifdef RADARPIM_RESET_SWRST_EN
    .sw_rst_req   (sw_rst_req),
`endif
    .rstnn_core   (rstnn_core),
    .rstnn_periph (rstnn_periph),
    .sys_ready    (sys_ready),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #5 clk_system = ~clk_system;

  // Drive inputs just after an edge, then advance one edge and settle.
  task automatic applyStimulus(input logic r, input logic p, input logic s);
    rst        = r;
    pll_locked = p;
    sw_rst_req = s;
    @(posedge clk_system);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic core, input logic periph,
                             input logic [7:0] cnt);
    checks++;
    if (rstnn_core !== core || rstnn_periph !== periph || sys_ready !== periph ||
        lock_loss_cnt !== cnt) begin
      failures++;
      $display("[TB] FAIL %s: got core=%b periph=%b ready=%b cnt=%0d, want core=%b periph=%b ready=%b cnt=%0d",
               name, rstnn_core, rstnn_periph, sys_ready, lock_loss_cnt, core, periph, periph, cnt);
    end
  endtask

  task automatic addVec(input logic r, input logic p, input logic c, input logic ph,
                        input logic [7:0] n);
    vec_t v;
    v.rst = r; v.pll = p; v.exp_core = c; v.exp_periph = ph; v.exp_cnt = n;
    vecs.push_back(v);
  endtask

  initial begin
    int exp_loss;

    // Reset held with lock present: everything stays asserted.
    addVec(1, 1, 0, 0, 0);
    addVec(1, 1, 0, 0, 0);
    // Release: entry k is edge k; core at edge 10, periph/ready at edge 14.
    for (int k = 0; k <= 15; k++) addVec(0, 1, k >= 10, k >= 14, 0);
    // Lock dropped 3 cycles: resets fall on the third edge, count becomes 1.
    addVec(0, 0, 1, 1, 0);
    addVec(0, 0, 1, 1, 0);
    addVec(0, 0, 0, 0, 1);
    // Relock: same latency as the first release.
    for (int k = 0; k <= 15; k++) addVec(0, 1, k >= 10, k >= 14, 1);

    #2;
    checkOutput("reset_initial", 0, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].pll, 1'b0);
      checkOutput($sformatf("vec%0d", i), vecs[i].exp_core, vecs[i].exp_periph, vecs[i].exp_cnt);
    end

    // Repeated lock losses from HOLD; counter saturates at 255.
    exp_loss = 1;
    for (int n = 0; n < 300; n++) begin
      repeat (3) applyStimulus(0, 1, 0);
      repeat (3) applyStimulus(0, 0, 0);
      exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
      checkOutput($sformatf("loss%0d", n), 0, 0, 8'(exp_loss));
    end
    checkOutput("loss_saturated", 0, 0, 255);

    // Reset pulsed while the HOLD counter is at 5 (edge 7 after lock).
    for (int k = 0; k <= 7; k++) applyStimulus(0, 1, 0);
    checkOutput("hold_before_rst", 0, 0, 255);
    applyStimulus(1, 1, 0);
    checkOutput("rst_mid_hold", 0, 0, 0);
    applyStimulus(1, 1, 0);
    checkOutput("rst_mid_hold2", 0, 0, 0);
    for (int k = 0; k <= 14; k++) begin
      applyStimulus(0, 1, 0);
      checkOutput($sformatf("restart_e%0d", k), k >= 10, k >= 14, 0);
    end

`ifdef RADARPIM_RESET_SWRST_EN
    // One-cycle software reset in RUN: core back 9 edges later, count untouched.
    applyStimulus(0, 1, 1);
    checkOutput("sw_pulse", 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(0, 1, 0);
      checkOutput($sformatf("sw_pulse_e%0d", k), k >= 9, 0, 0);
    end
    repeat (4) applyStimulus(0, 1, 0);
    checkOutput("sw_back_run", 1, 1, 0);
    // Held request keeps the sequencer parked in WAIT_LOCK.
    for (int k = 0; k < 12; k++) begin
      applyStimulus(0, 1, 1);
      checkOutput($sformatf("sw_hold%0d", k), 0, 0, 0);
    end
    for (int k = 1; k <= 9; k++) begin
      applyStimulus(0, 1, 0);
      checkOutput($sformatf("sw_rel_e%0d", k), k >= 9, 0, 0);
    end
    // Lock loss coinciding with a software request counts once as lock loss.
    repeat (4) applyStimulus(0, 1, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 0);
    applyStimulus(0, 0, 1);
    checkOutput("sw_and_loss", 0, 0, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/radarpim_reset_sequencer.md
RADARPIM_RESET_SEQUENCER -- requirements
Module: radarpim_reset_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 1024, SHALL set the clock cycles both resets stay asserted after PLL lock is seen; legal range 1..65535.
REQ-002 Parameter STAGE_GAP, default 16, SHALL set the clock cycles between core and peripheral reset release; legal range 1..65535.
REQ-003 Port clk_system, input, 1, SHALL be the system clock from the PLL stage; one clock, all logic on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the asynchronous, active-high reset.
REQ-005 Port pll_locked, input, 1, SHALL be the asynchronous PLL lock indication.
REQ-006 Port sw_rst_req, input, 1, SHALL be a software reset request, synchronous to clk_system; present only with RADARPIM_RESET_SWRST_EN.
REQ-007 Port rstnn_core, output, 1, SHALL be the active-low registered reset for processing cores.
REQ-008 Port rstnn_periph, output, 1, SHALL be the active-low registered reset for peripherals and interconnect.
REQ-009 Port sys_ready, output, 1, SHALL be high only in state RUN.
REQ-010 Port lock_loss_cnt, output, 8, SHALL count lock-loss events.

Function
REQ-011 pll_locked SHALL pass through a 2-flop synchronizer; lock_sync is its output.
REQ-012 FSM states SHALL be WAIT_LOCK, HOLD, REL_CORE, RUN, one-hot or binary at implementer's choice.
REQ-013 WAIT_LOCK: if lock_sync=1, next state HOLD with 16-bit counter cleared to 0.
REQ-014 HOLD: counter increments each cycle; at counter=HOLD_CYCLES-1, next state REL_CORE with counter cleared.
REQ-015 REL_CORE: counter increments each cycle; at counter=STAGE_GAP-1, next state RUN.
REQ-016 RUN SHALL be held until lock loss or software reset.
REQ-017 Outputs SHALL be registered from next state: rstnn_core=1 in REL_CORE/RUN; rstnn_periph=1 and sys_ready=1 in RUN only.
REQ-018 Latency: taking edge 0 as the first edge sampling pll_locked=1, rstnn_core SHALL rise at edge 2+HOLD_CYCLES and rstnn_periph at edge 2+HOLD_CYCLES+STAGE_GAP.
REQ-019 lock_sync=0 in HOLD, REL_CORE or RUN: next state WAIT_LOCK; both resets asserted on that edge; lock_loss_cnt increments.
REQ-020 lock_loss_cnt SHALL saturate at 255.
REQ-021 Lock-loss and software-reset events in the same cycle SHALL count once as lock loss.
REQ-022 Glitches on pll_locked shorter than one clock period SHALL need no filtering beyond the synchronizer.

Reset
REQ-023 rst=1 SHALL asynchronously force: state WAIT_LOCK, counter 0, synchronizer flops 0, rstnn_core=0, rstnn_periph=0, sys_ready=0, lock_loss_cnt=0.
REQ-024 rst asserted mid-sequence SHALL abort the sequence immediately, with no partial release.
REQ-025 After rst deasserts, the full lock-and-hold sequence SHALL restart from WAIT_LOCK.

Configuration
REQ-026 With macro RADARPIM_RESET_SWRST_EN defined: sw_rst_req=1 in HOLD, REL_CORE or RUN SHALL force next state WAIT_LOCK with both resets asserted; lock_loss_cnt is not changed.
REQ-027 While sw_rst_req stays high, the FSM SHALL stay in WAIT_LOCK.
REQ-028 Without the macro: sw_rst_req port and its logic absent; all other behaviour identical.

Verification (HOLD_CYCLES=8, STAGE_GAP=4)
REQ-029 rst=1, pll_locked=1 -> all outputs 0 and lock_loss_cnt=0 while rst is high.
REQ-030 rst released, pll_locked=1 sampled at edge 0 -> rstnn_core rises at edge 10, rstnn_periph and sys_ready rise at edge 14.
REQ-031 In RUN, pll_locked low for 3 cycles -> both resets low on the edge after lock_sync falls, lock_loss_cnt=1; relock -> release re-sequenced per REQ-018.
REQ-032 Force 300 lock-loss events -> lock_loss_cnt=255.
REQ-033 rst pulsed during HOLD at counter=5 -> outputs stay 0, and the sequence restarts with full HOLD_CYCLES after release.
REQ-034 With RADARPIM_RESET_SWRST_EN, sw_rst_req pulsed 1 cycle in RUN -> both resets low on the next edge, lock_loss_cnt unchanged, rstnn_core high again 9 edges later.
